// File: rtl/rr_arbiter_4_to_decoder.sv
`default_nettype none
// ============================================================================
// Module   : rr_arbiter_4_to_decoder
// Purpose  : 4-requester round-robin arbiter. It drives the select (a) and
//            enable (en) inputs of a downstream 2-to-4 decoder, whose one-hot
//            output is the grant vector. A grant is held until the owner
//            pulses done or drops its request. Priority then rotates to the
//            requester after the one just served. Every grant is followed by
//            exactly one idle bubble cycle, and re-arbitration happens in
//            that bubble.
// Ports    : clk      - system clock, rising-edge active
//            rst_n    - asynchronous active-low reset
//            req[3:0] - request vector, bit i = requester i
//            done     - owner finished (single-cycle pulse, used in GRANT only)
//            a[1:0]   - granted index (registered)
//            en       - grant valid (registered)
//            timeout  - one-cycle pulse on a forced release (registered)
// Options  : ARB_TIMEOUT_EN - when defined, a grant is force-released after
//            MAX_HOLD cycles. When it is undefined, timeout is constant 0 and
//            no hold counter exists.
// Revision : 1.0 - initial release
// ============================================================================
module rr_arbiter_4_to_decoder #(
    parameter int MAX_HOLD = 16,
    parameter int CNT_W    = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] req,
    input  logic       done,
    output logic [1:0] a,
    output logic       en,
    output logic       timeout
);

    localparam logic ST_IDLE  = 1'b0;
    localparam logic ST_GRANT = 1'b1;

    generate
        if ((MAX_HOLD < 2) || (MAX_HOLD > 255) || ((64'd1 << CNT_W) <= 64'(MAX_HOLD))) begin : g_param_check
            $error("rr_arbiter_4_to_decoder: illegal MAX_HOLD/CNT_W combination");
        end
    endgenerate

    logic       state_q, state_d;
    logic [1:0] last_q, last_d;
    logic [1:0] a_q, a_d;
    logic       en_q, en_d;
    logic       timeout_q, timeout_d;

    logic [1:0] w_winner;
    logic       w_found;
    logic [1:0] w_idx;
    logic       w_rel_normal;
    logic       w_rel_forced;

    // Scan the requesters starting one past the last-served index, wrapping
    // 3->0. The first set bit wins.
    always_comb begin
        w_winner = 2'b00;
        w_found  = 1'b0;
        w_idx    = 2'b00;
        for (int k = 1; k <= 4; k++) begin
            w_idx = last_q + 2'(k);
            if (!w_found && req[w_idx]) begin
                w_winner = w_idx;
                w_found  = 1'b1;
            end
        end
    end

    assign w_rel_normal = done | ~req[a_q];

`ifdef ARB_TIMEOUT_EN
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // A normal release on the same edge takes precedence over the timeout.
    assign w_rel_forced = (state_q == ST_GRANT) && !w_rel_normal && (cnt_q == HOLD_LAST);

    always_comb begin
        cnt_d = cnt_q;
        if (state_q == ST_IDLE) begin
            cnt_d = '0;
        end else if (!w_rel_normal && !w_rel_forced) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    assign w_rel_forced = 1'b0;
`endif

    // State register (all outputs are registered here too)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            last_q    <= 2'b11;
            a_q       <= 2'b00;
            en_q      <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            last_q    <= last_d;
            a_q       <= a_d;
            en_q      <= en_d;
            timeout_q <= timeout_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        case (state_q)
            ST_IDLE: begin
                if (w_found) begin
                    state_d = ST_GRANT;
                end
            end
            ST_GRANT: begin
                if (w_rel_normal || w_rel_forced) begin
                    state_d = ST_IDLE;
                    last_d  = a_q;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Output next-value logic; a keeps its value while the decoder is disabled
    always_comb begin
        a_d       = a_q;
        en_d      = 1'b0;
        timeout_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (w_found) begin
                    a_d  = w_winner;
                    en_d = 1'b1;
                end
            end
            ST_GRANT: begin
                en_d      = !(w_rel_normal || w_rel_forced);
                timeout_d = w_rel_forced;
            end
            default: ;
        endcase
    end

    assign a       = a_q;
    assign en      = en_q;
    assign timeout = timeout_q;

endmodule
`default_nettype wire

// File: tb/tb_rr_arbiter_4_to_decoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_rr_arbiter_4_to_decoder
// Purpose  : Self-checking bench for rr_arbiter_4_to_decoder. A reference
//            model predicts {a, en, timeout} after every rising edge and
//            queues the prediction. A monitor pops each prediction and
//            compares it with the DUT outputs on the falling edge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rr_arbiter_4_to_decoder;

    localparam int MH = 4;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] req   = 4'h0;
    logic       done  = 1'b0;
    logic [1:0] a;
    logic       en;
    logic       timeout;

    always #5 clk = ~clk;

    rr_arbiter_4_to_decoder #(
        .MAX_HOLD (MH),
        .CNT_W    (8)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req),
        .done    (done),
        .a       (a),
        .en      (en),
        .timeout (timeout)
    );

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [1:0] a;
        logic       en;
        logic       to;
    } exp_t;

    exp_t exp_q[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp_v, $time);
        end
    endtask

    // Reference model: the owner index, the last-served index and the number
    // of cycles the current grant has lasted.
    int m_a    = 0;
    int m_last = 3;
    int m_hold = 0;
    int m_c    = 0;
    bit m_en   = 0;
    bit m_to   = 0;

    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            if (!rst_n) begin
                m_a = 0; m_last = 3; m_hold = 0; m_en = 0; m_to = 0;
            end else if (!m_en) begin
                m_to = 0;
                for (int k = 1; k <= 4; k++) begin
                    m_c = (m_last + k) % 4;
                    if (req[m_c]) begin
                        m_a = m_c; m_en = 1; m_hold = 1;
                        break;
                    end
                end
            end else begin
                m_to = 0;
                if (done || !req[m_a]) begin
                    m_en = 0; m_last = m_a;
                end
`ifdef ARB_TIMEOUT_EN
                else if (m_hold == MH) begin
                    m_en = 0; m_last = m_a; m_to = 1;
                end else begin
                    m_hold++;
                end
`endif
            end
            e.a  = 2'(m_a);
            e.en = m_en;
            e.to = m_to;
            exp_q.push_back(e);
        end
    end

    // Monitor
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("a", 32'(a), 32'(e.a));
                chk("en", 32'(en), 32'(e.en));
                chk("timeout", 32'(timeout), 32'(e.to));
            end
        end
    end

    // Apply inputs, then advance one rising edge (time ends at edge + 2).
    task automatic cyc(input logic [3:0] r, input logic d);
        req  = r;
        done = d;
        @(posedge clk);
        #2;
    endtask

    initial begin
        logic [3:0] y;
        int         hold_en;

        // Reset with all requests active
        req = 4'hF;
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b1;
        cyc(4'hF, 1'b0);
        y = en ? (4'b0001 << a) : 4'b0000;
        chk("decoder_y_first", 32'(y), 32'h1);

        // Rotation with done pulses
        for (int i = 0; i < 12; i++) cyc(4'hF, (i % 2) == 0);

        // Request drop, wrap back to requester 0
        cyc(4'h0, 1'b0);
        cyc(4'h0, 1'b0);
        cyc(4'b0001, 1'b0);
        cyc(4'b0001, 1'b1);
        cyc(4'b0101, 1'b0);
        cyc(4'b0101, 1'b0);
        cyc(4'b0001, 1'b0);
        cyc(4'b0101, 1'b0);
        cyc(4'b0101, 1'b0);

        // Simultaneous done and request drop while requester 1 owns the grant
        cyc(4'h0, 1'b0);
        cyc(4'h0, 1'b0);
        cyc(4'b0010, 1'b0);
        cyc(4'b0010, 1'b0);
        cyc(4'b1100, 1'b1);
        cyc(4'b1100, 1'b0);
        cyc(4'b1100, 1'b0);

        // Asynchronous reset while requester 2 owns the grant
        cyc(4'h0, 1'b0);
        cyc(4'h0, 1'b0);
        cyc(4'b0100, 1'b0);
        cyc(4'b0100, 1'b0);
        chk("granted_before_reset", 32'({en, a}), 32'h6);
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("async_en_drop", 32'(en), 32'h0);
        chk("async_a_reset", 32'(a), 32'h0);
        req = 4'hF;
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        cyc(4'hF, 1'b0);
        chk("restart_at_req0", 32'({en, a}), 32'h4);

        // Long hold: released only by the timeout when it is enabled
        cyc(4'h0, 1'b0);
        cyc(4'h0, 1'b0);
        hold_en = 0;
        for (int i = 0; i < 20; i++) begin
            cyc(4'b0001, 1'b0);
            if (en) hold_en++;
        end
`ifndef ARB_TIMEOUT_EN
        chk("hold_no_timeout_en_cycles", 32'(hold_en), 32'd20);
`endif

        // Randomized traffic with sticky requests and occasional done pulses
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) == 0) req = 4'($urandom_range(0, 15));
            cyc(req, $urandom_range(0, 4) == 0);
        end

        @(negedge clk);
        #1;
        chk("queue_drained", 32'(exp_q.size()), 32'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
